// File: rtl/queue_param.sv
// queue_param: parametrised ready/valid FIFO built from a DEPTH x WIDTH register
// array with wrap-around pointers and a maybe_full flag. Optional FLOW
// (empty queue passes data straight through) and PIPE (full queue accepts when
// the head is taken in the same cycle). A synchronous flush clears the state.
// Define QUEUE_PARAM_ASSERT_EN to compile in the protocol/sanity checker.

`ifdef QUEUE_PARAM_ASSERT_EN
module queue_param_checker #(
  parameter int WIDTH = 109,
  parameter int DEPTH = 12,
  parameter int FLOW  = 0,
  parameter int CW    = 4
) (
  input logic             clock,
  input logic             reset_n,
  input logic             flush,
  input logic             enq_valid,
  input logic             enq_ready,
  input logic             deq_valid,
  input logic             deq_ready,
  input logic [WIDTH-1:0] deq_bits,
  input logic [CW-1:0]    count,
  input logic             full_s,
  input logic             empty_s,
  input logic             deq_fire_s,
  input logic             do_enq_s,
  input logic             do_deq_s
);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  a_count_range: assert property (@(posedge clock) disable iff (!reset_n)
    {1'b0, count} <= DEPTH_W)
    else $error("%m: count exceeds DEPTH");

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(do_enq_s && full_s && !deq_fire_s))
    else $error("%m: enqueue into full queue");

  a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(do_deq_s && empty_s))
    else $error("%m: dequeue from empty queue");

  a_enq_hold: assert property (@(posedge clock) disable iff (!reset_n)
    (enq_valid && !enq_ready && !flush) |=> enq_valid)
    else $error("%m: enq_valid dropped before handshake");

  a_deq_stable: assert property (@(posedge clock) disable iff (!reset_n)
    ((FLOW == 0) && deq_valid && !deq_ready && !flush) |=> $stable(deq_bits))
    else $error("%m: deq_bits changed while stalled");
endmodule
`endif

module queue_param #(
  parameter int WIDTH = 109,
  parameter int DEPTH = 12,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits,
  output logic [CW-1:0]    count
);
  // Pointer width; DEPTH=1 still needs one (constant-zero) bit.
  localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(DEPTH);
  localparam bit          FLOW_EN  = (FLOW != 0);
  localparam bit          PIPE_EN  = (PIPE != 0);

  logic [WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [PW-1:0]    enq_ptr_r;
  logic [PW-1:0]    deq_ptr_r;
  logic             maybe_full_r;

  logic [PW-1:0]    enq_ptr_nxt_s;
  logic [PW-1:0]    deq_ptr_nxt_s;
  logic             maybe_full_nxt_s;

  logic             ptr_match_s;
  logic             empty_s;
  logic             full_s;
  logic             enq_fire_s;
  logic             deq_fire_s;
  logic             do_enq_s;
  logic             do_deq_s;
  logic [CW:0]      count_wide_s;
  logic             count_msb_unused_s;

  assign ptr_match_s = (enq_ptr_r == deq_ptr_r);
  assign empty_s     = ptr_match_s && !maybe_full_r;
  assign full_s      = ptr_match_s && maybe_full_r;

  // Handshake outputs and head data; FLOW bypasses storage when empty.
  always_comb begin
    enq_ready = !full_s || (PIPE_EN && deq_ready);
    deq_valid = !empty_s || (FLOW_EN && enq_valid);
    if (FLOW_EN && empty_s) begin
      deq_bits = enq_bits;
    end else begin
      deq_bits = mem_r[deq_ptr_r];
    end
  end

  // Fire qualification: a flowed beat neither writes storage nor moves deq_ptr.
  always_comb begin
    enq_fire_s = enq_valid && enq_ready;
    deq_fire_s = deq_valid && deq_ready;
    do_enq_s   = enq_fire_s && !(FLOW_EN && empty_s && deq_ready);
    do_deq_s   = deq_fire_s && !(FLOW_EN && empty_s);
  end

  // Occupancy from pointer distance, widened by one bit to absorb DEPTH+enq.
  always_comb begin
    count_wide_s = '0;
    if (ptr_match_s) begin
      if (maybe_full_r) begin
        count_wide_s = DEPTH_W;
      end else begin
        count_wide_s = '0;
      end
    end else if (enq_ptr_r > deq_ptr_r) begin
      count_wide_s = (CW+1)'(enq_ptr_r) - (CW+1)'(deq_ptr_r);
    end else begin
      count_wide_s = DEPTH_W + (CW+1)'(enq_ptr_r) - (CW+1)'(deq_ptr_r);
    end
  end

  assign count              = count_wide_s[CW-1:0];
  assign count_msb_unused_s = count_wide_s[CW];

  // Next pointer/flag state; flush overrides any transfer this cycle.
  always_comb begin
    enq_ptr_nxt_s    = enq_ptr_r;
    deq_ptr_nxt_s    = deq_ptr_r;
    maybe_full_nxt_s = maybe_full_r;
    if (flush) begin
      enq_ptr_nxt_s    = '0;
      deq_ptr_nxt_s    = '0;
      maybe_full_nxt_s = 1'b0;
    end else begin
      if (do_enq_s) begin
        enq_ptr_nxt_s = (enq_ptr_r == LAST_PTR) ? '0 : enq_ptr_r + PW'(1);
      end else begin
        enq_ptr_nxt_s = enq_ptr_r;
      end
      if (do_deq_s) begin
        deq_ptr_nxt_s = (deq_ptr_r == LAST_PTR) ? '0 : deq_ptr_r + PW'(1);
      end else begin
        deq_ptr_nxt_s = deq_ptr_r;
      end
      if (do_enq_s != do_deq_s) begin
        maybe_full_nxt_s = do_enq_s;
      end else begin
        maybe_full_nxt_s = maybe_full_r;
      end
    end
  end

  // Pointer and full-flag registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_ptr_r    <= '0;
      deq_ptr_r    <= '0;
      maybe_full_r <= 1'b0;
    end else begin
      enq_ptr_r    <= enq_ptr_nxt_s;
      deq_ptr_r    <= deq_ptr_nxt_s;
      maybe_full_r <= maybe_full_nxt_s;
    end
  end

  // Payload storage; deliberately unreset, stale contents are never exposed as valid.
  always_ff @(posedge clock) begin
    if (do_enq_s && !flush) begin
      mem_r[enq_ptr_r] <= enq_bits;
    end
  end

`ifdef QUEUE_PARAM_ASSERT_EN
  queue_param_checker #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .FLOW  (FLOW),
    .CW    (CW)
  ) u_checker (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .enq_valid  (enq_valid),
    .enq_ready  (enq_ready),
    .deq_valid  (deq_valid),
    .deq_ready  (deq_ready),
    .deq_bits   (deq_bits),
    .count      (count),
    .full_s     (full_s),
    .empty_s    (empty_s),
    .deq_fire_s (deq_fire_s),
    .do_enq_s   (do_enq_s),
    .do_deq_s   (do_deq_s)
  );
`endif

endmodule

// File: tb/tb_queue_param.sv
// Directed self-checking bench for queue_param: three instances (default,
// FLOW=1, PIPE=1) share one stimulus set; each test checks the relevant one.
module tb_queue_param;
  logic         clock;
  logic         reset_n;
  logic         flush;
  logic         enq_valid;
  logic         deq_ready;
  logic [108:0] enq_bits;

  logic         b_enq_ready, b_deq_valid;
  logic [108:0] b_deq_bits;
  logic [3:0]   b_count;
  logic         f_enq_ready, f_deq_valid;
  logic [108:0] f_deq_bits;
  logic [3:0]   f_count;
  logic         p_enq_ready, p_deq_valid;
  logic [108:0] p_deq_bits;
  logic [3:0]   p_count;

  int n_cmp;
  int n_err;

  queue_param u_base (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(b_enq_ready), .enq_bits(enq_bits),
    .deq_valid(b_deq_valid), .deq_ready(deq_ready), .deq_bits(b_deq_bits),
    .count(b_count)
  );

  queue_param #(.FLOW(1)) u_flow (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(f_enq_ready), .enq_bits(enq_bits),
    .deq_valid(f_deq_valid), .deq_ready(deq_ready), .deq_bits(f_deq_bits),
    .count(f_count)
  );

  queue_param #(.PIPE(1)) u_pipe (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(p_enq_ready), .enq_bits(enq_bits),
    .deq_valid(p_deq_valid), .deq_ready(deq_ready), .deq_bits(p_deq_bits),
    .count(p_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_flush;
    flush = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0;
    tick;
    flush = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_bits = '0;
    #1;
    n_cmp++; if (b_enq_ready !== 1'b1) begin n_err++; $display("FAIL rst_enq_ready: got %b want 1", b_enq_ready); end
    n_cmp++; if (b_deq_valid !== 1'b0) begin n_err++; $display("FAIL rst_deq_valid: got %b want 0", b_deq_valid); end
    n_cmp++; if (b_count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", b_count); end
    tick; tick;
    reset_n = 1'b1;
    enq_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      enq_bits = 109'(i);
      tick;
    end
    n_cmp++; if (b_count !== 4'd3) begin n_err++; $display("FAIL pre_rst_count: got %0d want 3", b_count); end
    enq_bits = 109'(4); deq_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (b_enq_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_enq_ready: got %b want 1", b_enq_ready); end
    n_cmp++; if (b_deq_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_deq_valid: got %b want 0", b_deq_valid); end
    n_cmp++; if (b_count !== 4'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", b_count); end
    n_cmp++; if (f_deq_valid !== 1'b1) begin n_err++; $display("FAIL mid_rst_flow_deq_valid: got %b want 1", f_deq_valid); end
    n_cmp++; if (p_count !== 4'd0) begin n_err++; $display("FAIL mid_rst_pipe_count: got %0d want 0", p_count); end
    enq_valid = 1'b0; deq_ready = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_fill_drain;
    enq_valid = 1'b1; deq_ready = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      enq_bits = 109'(i);
      #1;
      n_cmp++; if (b_enq_ready !== 1'b1) begin n_err++; $display("FAIL fill_enq_ready[%0d]: got %b want 1", i, b_enq_ready); end
      tick;
    end
    n_cmp++; if (b_count !== 4'd12) begin n_err++; $display("FAIL fill_count: got %0d want 12", b_count); end
    n_cmp++; if (b_enq_ready !== 1'b0) begin n_err++; $display("FAIL full_enq_ready: got %b want 0", b_enq_ready); end
    enq_bits = 109'(13);
    tick;
    n_cmp++; if (b_count !== 4'd12) begin n_err++; $display("FAIL 13th_count: got %0d want 12", b_count); end
    enq_valid = 1'b0; deq_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      #1;
      n_cmp++; if (b_deq_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %b want 1", i, b_deq_valid); end
      n_cmp++; if (b_deq_bits !== 109'(i)) begin n_err++; $display("FAIL drain_bits[%0d]: got %0h want %0h", i, b_deq_bits, i); end
      tick;
    end
    #1;
    n_cmp++; if (b_deq_valid !== 1'b0) begin n_err++; $display("FAIL drained_valid: got %b want 0", b_deq_valid); end
    n_cmp++; if (b_count !== 4'd0) begin n_err++; $display("FAIL drained_count: got %0d want 0", b_count); end
    deq_ready = 1'b0;
  endtask

  task automatic test_wrap;
    do_flush;
    enq_valid = 1'b1; deq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enq_bits = 109'(100 + i);
      tick;
    end
    n_cmp++; if (b_count !== 4'd5) begin n_err++; $display("FAIL wrap_start_count: got %0d want 5", b_count); end
    deq_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      enq_bits = 109'(105 + k);
      #1;
      n_cmp++; if (b_deq_bits !== 109'(100 + k)) begin n_err++; $display("FAIL wrap_bits[%0d]: got %0h want %0h", k, b_deq_bits, 100 + k); end
      n_cmp++; if (b_count !== 4'd5) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want 5", k, b_count); end
      tick;
    end
    enq_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (b_deq_bits !== 109'(140 + k)) begin n_err++; $display("FAIL wrap_tail[%0d]: got %0h want %0h", k, b_deq_bits, 140 + k); end
      tick;
    end
    n_cmp++; if (b_count !== 4'd0) begin n_err++; $display("FAIL wrap_end_count: got %0d want 0", b_count); end
    deq_ready = 1'b0;
  endtask

  task automatic test_flow;
    do_flush;
    enq_valid = 1'b1; enq_bits = 109'h0ABC; deq_ready = 1'b1;
    #1;
    n_cmp++; if (f_deq_valid !== 1'b1) begin n_err++; $display("FAIL flow_valid: got %b want 1", f_deq_valid); end
    n_cmp++; if (f_deq_bits !== 109'h0ABC) begin n_err++; $display("FAIL flow_bits: got %0h want abc", f_deq_bits); end
    n_cmp++; if (f_count !== 4'd0) begin n_err++; $display("FAIL flow_count_now: got %0d want 0", f_count); end
    n_cmp++; if (b_deq_valid !== 1'b0) begin n_err++; $display("FAIL noflow_valid: got %b want 0", b_deq_valid); end
    tick;
    n_cmp++; if (f_count !== 4'd0) begin n_err++; $display("FAIL flow_count_after: got %0d want 0", f_count); end
    enq_valid = 1'b0;
    #1;
    n_cmp++; if (f_deq_valid !== 1'b0) begin n_err++; $display("FAIL flow_idle_valid: got %b want 0", f_deq_valid); end
    deq_ready = 1'b0;
  endtask

  task automatic test_pipe;
    do_flush;
    enq_valid = 1'b1; deq_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      enq_bits = 109'(8'h21 + i);
      tick;
    end
    n_cmp++; if (p_count !== 4'd12) begin n_err++; $display("FAIL pipe_fill_count: got %0d want 12", p_count); end
    n_cmp++; if (p_enq_ready !== 1'b0) begin n_err++; $display("FAIL pipe_stall_ready: got %b want 0", p_enq_ready); end
    enq_bits = 109'h2D; deq_ready = 1'b1;
    #1;
    n_cmp++; if (p_enq_ready !== 1'b1) begin n_err++; $display("FAIL pipe_enq_ready: got %b want 1", p_enq_ready); end
    n_cmp++; if (b_enq_ready !== 1'b0) begin n_err++; $display("FAIL nopipe_enq_ready: got %b want 0", b_enq_ready); end
    tick;
    enq_valid = 1'b0;
    n_cmp++; if (p_count !== 4'd12) begin n_err++; $display("FAIL pipe_count: got %0d want 12", p_count); end
    n_cmp++; if (b_count !== 4'd11) begin n_err++; $display("FAIL nopipe_count: got %0d want 11", b_count); end
    for (int i = 0; i < 12; i++) begin
      #1;
      n_cmp++; if (p_deq_bits !== 109'(8'h22 + i)) begin n_err++; $display("FAIL pipe_drain[%0d]: got %0h want %0h", i, p_deq_bits, 8'h22 + i); end
      tick;
    end
    deq_ready = 1'b0;
  endtask

  task automatic test_flush;
    do_flush;
    enq_valid = 1'b1; deq_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      enq_bits = 109'(8'h51 + i);
      tick;
    end
    n_cmp++; if (b_count !== 4'd7) begin n_err++; $display("FAIL flush_pre_count: got %0d want 7", b_count); end
    flush = 1'b1; enq_bits = 109'h58; deq_ready = 1'b1;
    #1;
    n_cmp++; if (b_enq_ready !== 1'b1) begin n_err++; $display("FAIL flush_cycle_ready: got %b want 1", b_enq_ready); end
    n_cmp++; if (b_deq_valid !== 1'b1) begin n_err++; $display("FAIL flush_cycle_valid: got %b want 1", b_deq_valid); end
    tick;
    flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    #1;
    n_cmp++; if (b_count !== 4'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", b_count); end
    n_cmp++; if (b_deq_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", b_deq_valid); end
    enq_valid = 1'b1; enq_bits = 109'h61;
    tick;
    enq_valid = 1'b0;
    #1;
    n_cmp++; if (b_count !== 4'd1) begin n_err++; $display("FAIL post_flush_count: got %0d want 1", b_count); end
    n_cmp++; if (b_deq_bits !== 109'h61) begin n_err++; $display("FAIL post_flush_bits: got %0h want 61", b_deq_bits); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset;
    test_fill_drain;
    test_wrap;
    test_flow;
    test_pipe;
    test_flush;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
